// File: rtl/local_threshold_packer_pkg.sv
// Shared constants for the local threshold packer and its centring delay line.
package local_threshold_packer_pkg;
   typedef logic [0:0] state_t;
   localparam state_t STATE_IDLE = 1'b0;
   localparam state_t STATE_RUN  = 1'b1;
   localparam int     SOF_BIT    = 8;
   localparam int     PIXEL_W    = 9;
endpackage

// File: rtl/local_threshold_packer_pixel_delay_line.sv
// Depth x width shift register with enable; dout is the entry loaded DEPTH enables ago.
module pixel_delay_line
   import local_threshold_packer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = PIXEL_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] taps_reg  [DEPTH];
   logic [WIDTH-1:0] taps_next [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
         if (gi == 0) begin : g_head
            assign taps_next[gi] = din;
         end else begin : g_body
            assign taps_next[gi] = taps_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) taps_reg[i] <= '0;
      end else if (enable) begin
         for (int i = 0; i < DEPTH; i++) taps_reg[i] <= taps_next[i];
      end
   end

   assign dout = taps_reg[DEPTH-1];
endmodule

// File: rtl/local_threshold_packer.sv
// Thresholds each centred pixel against its window average and packs the bits into words.
// Optional THRESHOLD_OFFSET_EN adds a threshold_offset input added to the average.
module local_threshold_packer
   import local_threshold_packer_pkg::*;
#(
   parameter int RADIUS     = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int PACK_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [8:0]            pixel,
   input  logic                  pixel_valid,
   input  logic [7:0]            local_average,
   input  logic                  local_average_valid,
`ifdef THRESHOLD_OFFSET_EN
   input  logic [7:0]            threshold_offset,
`endif
   output logic [PACK_WIDTH-1:0] out_word,
   output logic                  out_word_valid,
   output logic                  out_sof,
   output logic                  sync_error
);
   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int POS_W = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
   localparam logic [COL_W-1:0] EDGE_LO  = COL_W'(RADIUS);
   localparam logic [COL_W-1:0] EDGE_HI  = COL_W'(IMG_WIDTH - RADIUS);
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(PACK_WIDTH - 1);

   logic                  accept, mismatch, delayed_sof, active, mid_line_sof, thr_bit;
   logic [8:0]            delayed, offset_ext, limit;
   logic [COL_W-1:0]      col_eff;
   logic [POS_W-1:0]      pos_eff;
   state_t                state_reg, state_next;
   logic [COL_W-1:0]      col_reg, col_next;
   logic [POS_W-1:0]      pos_reg, pos_next;
   logic [PACK_WIDTH-1:0] pack_reg, pack_next;
   logic                  sof_pending_reg, sof_pending_next;
   logic [PACK_WIDTH-1:0] out_word_reg, out_word_next;
   logic                  out_valid_reg, out_valid_next;
   logic                  out_sof_reg, out_sof_next;
   logic                  sync_error_reg, sync_error_next;

   assign accept   = pixel_valid && local_average_valid;
   assign mismatch = pixel_valid ^ local_average_valid;

   pixel_delay_line #(
      .DEPTH (RADIUS),
      .WIDTH (PIXEL_W)
   ) u_delay (
      .clk    (clk),
      .reset  (reset),
      .enable (accept),
      .din    (pixel),
      .dout   (delayed)
   );

`ifdef THRESHOLD_OFFSET_EN
   assign offset_ext = {1'b0, threshold_offset};
`else
   assign offset_ext = '0;
`endif

   // A delayed SOF always lands in column 0, whether it starts or restarts a frame.
   assign delayed_sof  = delayed[SOF_BIT];
   assign col_eff      = delayed_sof ? '0 : col_reg;
   assign pos_eff      = delayed_sof ? '0 : pos_reg;
   assign active       = accept && (state_reg == STATE_RUN || delayed_sof);
   assign mid_line_sof = accept && delayed_sof && state_reg == STATE_RUN && col_reg != '0;
   assign limit        = {1'b0, local_average} + offset_ext;
   assign thr_bit      = (col_eff >= EDGE_LO) && (col_eff <= EDGE_HI) &&
                         ({1'b0, delayed[7:0]} > limit);

   always_comb begin
      state_next       = state_reg;
      col_next         = col_reg;
      pos_next         = pos_reg;
      pack_next        = pack_reg;
      sof_pending_next = sof_pending_reg;
      out_word_next    = out_word_reg;
      out_valid_next   = 1'b0;
      out_sof_next     = 1'b0;
      sync_error_next  = mismatch || mid_line_sof;
      if (active) begin
         state_next          = STATE_RUN;
         pack_next           = delayed_sof ? '0 : pack_reg;
         pack_next[pos_eff]  = thr_bit;
         sof_pending_next    = sof_pending_reg || delayed_sof;
         col_next            = (col_eff == LAST_COL) ? '0 : col_eff + 1'b1;
         if (pos_eff == LAST_POS) begin
            out_word_next    = pack_next;
            out_valid_next   = 1'b1;
            out_sof_next     = sof_pending_next;
            sof_pending_next = 1'b0;
            pack_next        = '0;
            pos_next         = '0;
         end else begin
            pos_next = pos_eff + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= STATE_IDLE;
         col_reg         <= '0;
         pos_reg         <= '0;
         pack_reg        <= '0;
         sof_pending_reg <= 1'b0;
         out_word_reg    <= '0;
         out_valid_reg   <= 1'b0;
         out_sof_reg     <= 1'b0;
         sync_error_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         col_reg         <= col_next;
         pos_reg         <= pos_next;
         pack_reg        <= pack_next;
         sof_pending_reg <= sof_pending_next;
         out_word_reg    <= out_word_next;
         out_valid_reg   <= out_valid_next;
         out_sof_reg     <= out_sof_next;
         sync_error_reg  <= sync_error_next;
      end
   end

   assign out_word       = out_word_reg;
   assign out_word_valid = out_valid_reg;
   assign out_sof        = out_sof_reg;
   assign sync_error     = sync_error_reg;
endmodule

// File: tb/tb_local_threshold_packer.sv
// Scoreboard bench for local_threshold_packer; offset scenario runs when THRESHOLD_OFFSET_EN is defined.
`timescale 1ns/1ps
module tb_local_threshold_packer;
   localparam int RADIUS     = 8;
   localparam int IMG_WIDTH  = 640;
   localparam int PACK_WIDTH = 8;
   localparam int WPL        = IMG_WIDTH / PACK_WIDTH;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] pixel;
   logic       pixel_valid;
   logic [7:0] local_average;
   logic       local_average_valid;
`ifdef THRESHOLD_OFFSET_EN
   logic [7:0] threshold_offset;
`endif
   logic [7:0] out_word;
   logic       out_word_valid, out_sof, sync_error;

   always #5 clk = ~clk;

   local_threshold_packer #(
      .RADIUS     (RADIUS),
      .IMG_WIDTH  (IMG_WIDTH),
      .PACK_WIDTH (PACK_WIDTH)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .pixel               (pixel),
      .pixel_valid         (pixel_valid),
      .local_average       (local_average),
      .local_average_valid (local_average_valid),
`ifdef THRESHOLD_OFFSET_EN
      .threshold_offset    (threshold_offset),
`endif
      .out_word            (out_word),
      .out_word_valid      (out_word_valid),
      .out_sof             (out_sof),
      .sync_error          (sync_error)
   );

   int         checks = 0;
   int         failures = 0;
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int         exp_sync, got_sync;

   logic [8:0] m_hist[$];
   bit         m_run, m_sofp;
   int         m_col, m_offset;
   logic [7:0] m_word;

   // Observed words ({sof, word}) and sync pulses, sampled after each edge
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         if (out_word_valid) got_q.push_back({out_sof, out_word});
         if (sync_error) got_sync++;
      end
   end

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < RADIUS; i++) m_hist.push_back(9'd0);
      m_run = 0; m_sofp = 0; m_col = 0; m_word = 8'd0;
   endtask

   task automatic model_accept(input logic [8:0] pix, input logic [7:0] avg);
      logic [8:0] d;
      bit b;
      d = m_hist.pop_front();
      m_hist.push_back(pix);
      if (d[8]) begin
         if (m_run && m_col != 0) exp_sync++;
         m_run = 1; m_col = 0; m_word = 8'd0; m_sofp = 1;
      end
      if (m_run) begin
         b = (m_col >= RADIUS) && (m_col <= IMG_WIDTH - RADIUS) &&
             (int'(d[7:0]) > int'(avg) + m_offset);
         m_word[m_col % PACK_WIDTH] = b;
         if (m_col % PACK_WIDTH == PACK_WIDTH - 1) begin
            exp_q.push_back({m_sofp, m_word});
            m_sofp = 0; m_word = 8'd0;
         end
         m_col = (m_col + 1) % IMG_WIDTH;
      end
   endtask

   task automatic drive(input bit pv, input bit av, input logic [8:0] pix, input logic [7:0] avg);
      @(negedge clk);
      pixel_valid = pv; local_average_valid = av; pixel = pix; local_average = avg;
      if (pv && av) model_accept(pix, avg);
      else if (pv ^ av) exp_sync++;
   endtask

   task automatic settle(input int n);
      repeat (n) drive(0, 0, 9'd0, 8'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; pixel_valid = 0; local_average_valid = 0; pixel = '0; local_average = '0;
      repeat (2) @(negedge clk);
      reset = 0;
      model_reset();
      exp_q.delete(); got_q.delete();
      exp_sync = 0; got_sync = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_word !== 8'd0) begin failures++; $display("FAIL reset_word: got %h want 00", out_word); end
      checks++; if (out_word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_word_valid); end
      checks++; if (out_sof !== 1'b0) begin failures++; $display("FAIL reset_sof: got %b want 0", out_sof); end
      checks++; if (sync_error !== 1'b0) begin failures++; $display("FAIL reset_sync: got %b want 0", sync_error); end
      // SOF left inside the delay line must not survive a reset
      for (int i = 0; i < 20; i++) drive(1, 1, {(i == 14), 8'd200}, 8'd10);
      do_reset();
      checks++; if (out_word_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b want 0", out_word_valid); end
      for (int i = 0; i < 16; i++) drive(1, 1, {1'b0, 8'd200}, 8'd10);
      settle(4);
      $display("test_reset: words=%0d sync=%0d", got_q.size(), got_sync);
      checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL midreset_words: got %0d want 0", got_q.size()); end
      checks++; if (got_sync !== 0) begin failures++; $display("FAIL midreset_sync: got %0d want 0", got_sync); end
   endtask

   task automatic test_uniform();
      logic [8:0] e, g;
      do_reset();
      for (int i = 0; i < 2 * IMG_WIDTH + RADIUS; i++) drive(1, 1, {(i == 0), 8'd100}, 8'd100);
      settle(4);
      $display("test_uniform: words=%0d sync=%0d", got_q.size(), got_sync);
      checks++; if (got_q.size() !== 2 * WPL) begin failures++; $display("FAIL uniform_count: got %0d want %0d", got_q.size(), 2 * WPL); end
      for (int i = 0; i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== {(i == 0), 8'h00}) begin failures++; $display("FAIL uniform_word%0d: got %h want %h", i, got_q[i], {(i == 0), 8'h00}); end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL uniform_sb: got none want %h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL uniform_sb: got %h want %h", g, e); end end
      end
      checks++; if (got_sync !== exp_sync) begin failures++; $display("FAIL uniform_sync: got %0d want %0d", got_sync, exp_sync); end
   endtask

   task automatic test_alternating();
      logic [8:0] e, g;
      do_reset();
      for (int i = 0; i < IMG_WIDTH + RADIUS; i++) drive(1, 1, {(i == 0), (i % 2 == 1) ? 8'd200 : 8'd0}, 8'd100);
      settle(4);
      $display("test_alternating: words=%0d first=%h second=%h last=%h", got_q.size(), got_q[0], got_q[1], got_q[WPL-1]);
      checks++; if (got_q[0] !== 9'h100) begin failures++; $display("FAIL alt_first: got %h want 100", got_q[0]); end
      checks++; if (got_q[1] !== 9'h0AA) begin failures++; $display("FAIL alt_interior: got %h want 0aa", got_q[1]); end
      checks++; if (got_q[WPL-1] !== 9'h000) begin failures++; $display("FAIL alt_last: got %h want 000", got_q[WPL-1]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL alt_sb: got none want %h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL alt_sb: got %h want %h", g, e); end end
      end
      checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL alt_extra: got %0d extra words", got_q.size()); end
   endtask

   task automatic test_pre_sof();
      logic [8:0] e, g;
      do_reset();
      for (int i = 0; i < 16; i++) drive(1, 1, {1'b0, 8'd250}, 8'd0);
      for (int i = 0; i < RADIUS; i++) drive(1, 1, {(i == 0), 8'($urandom_range(0, 255))}, 8'($urandom_range(0, 255)));
      settle(3);
      checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL presof_early: got %0d words want 0", got_q.size()); end
      for (int i = 0; i < 16; i++) drive(1, 1, {1'b0, 8'($urandom_range(0, 255))}, 8'($urandom_range(0, 255)));
      settle(4);
      $display("test_pre_sof: words=%0d", got_q.size());
      checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL presof_count: got %0d want 2", got_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL presof_sb: got none want %h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL presof_sb: got %h want %h", g, e); end end
      end
   endtask

   task automatic test_mid_line_sof();
      logic [8:0] e, g;
      do_reset();
      for (int i = 0; i < 300 + 24 + RADIUS; i++)
         drive(1, 1, {(i == 0 || i == 300), 8'($urandom_range(0, 255))}, 8'($urandom_range(0, 255)));
      settle(4);
      $display("test_mid_line_sof: words=%0d sync=%0d", got_q.size(), got_sync);
      checks++; if (got_sync !== 1) begin failures++; $display("FAIL midsof_sync: got %0d want 1", got_sync); end
      checks++; if (got_q.size() !== 40) begin failures++; $display("FAIL midsof_count: got %0d want 40", got_q.size()); end
      checks++; if (got_q[37] !== 9'h100) begin failures++; $display("FAIL midsof_restart: got %h want 100", got_q[37]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL midsof_sb: got none want %h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL midsof_sb: got %h want %h", g, e); end end
      end
   endtask

   task automatic test_valid_mismatch();
      logic [8:0] e, g;
      do_reset();
      for (int i = 0; i < IMG_WIDTH + RADIUS; i++) begin
         if (i == 100) drive(1, 0, 9'h1FF, 8'd0);
         if (i == 200) drive(0, 1, 9'h1FF, 8'd0);
         if (i == 300) settle(3);
         drive(1, 1, {(i == 0), 8'($urandom_range(0, 255))}, 8'($urandom_range(0, 255)));
      end
      settle(4);
      $display("test_valid_mismatch: words=%0d sync=%0d", got_q.size(), got_sync);
      checks++; if (got_sync !== 2) begin failures++; $display("FAIL mismatch_sync: got %0d want 2", got_sync); end
      checks++; if (got_q.size() !== WPL) begin failures++; $display("FAIL mismatch_count: got %0d want %0d", got_q.size(), WPL); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL mismatch_sb: got none want %h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL mismatch_sb: got %h want %h", g, e); end end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] e, g;
      do_reset();
      for (int i = 0; i < 2 * IMG_WIDTH + RADIUS; i++)
         drive(1, 1, {(i == 0 || i == IMG_WIDTH), 8'($urandom_range(0, 255))}, 8'($urandom_range(0, 255)));
      settle(4);
      $display("test_back_to_back: words=%0d sync=%0d", got_q.size(), got_sync);
      checks++; if (got_sync !== 0) begin failures++; $display("FAIL b2b_sync: got %0d want 0", got_sync); end
      checks++; if (got_q[WPL][8] !== 1'b1) begin failures++; $display("FAIL b2b_sof2: got %b want 1", got_q[WPL][8]); end
      checks++; if (got_q[WPL-1][8] !== 1'b0) begin failures++; $display("FAIL b2b_nosof: got %b want 0", got_q[WPL-1][8]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (got_q.size() == 0) begin failures++; $display("FAIL b2b_sb: got none want %h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL b2b_sb: got %h want %h", g, e); end end
      end
      checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL b2b_extra: got %0d extra words", got_q.size()); end
   endtask

`ifdef THRESHOLD_OFFSET_EN
   task automatic test_offset();
      logic [8:0] e, g;
      logic [7:0] want [2];
      int         offs [2];
      logic [7:0] p8, p9;
      offs[0] = 20;  want[0] = 8'h02;
      offs[1] = 200; want[1] = 8'h00;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         threshold_offset = 8'(offs[k]);
         m_offset = offs[k];
         p8 = (k == 0) ? 8'd115 : 8'd255;
         p9 = (k == 0) ? 8'd121 : 8'd255;
         for (int i = 0; i < 16 + RADIUS; i++)
            drive(1, 1, {(i == 0), (i == 8) ? p8 : (i == 9) ? p9 : 8'd0}, 8'd100);
         settle(4);
         $display("test_offset: offset=%0d words=%0d second=%h", offs[k], got_q.size(), got_q[1]);
         checks++; if (got_q[1] !== {1'b0, want[k]}) begin failures++; $display("FAIL offset_word: offset=%0d got %h want %h", offs[k], got_q[1], {1'b0, want[k]}); end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (got_q.size() == 0) begin failures++; $display("FAIL offset_sb: got none want %h", e); end
            else begin g = got_q.pop_front(); if (g !== e) begin failures++; $display("FAIL offset_sb: got %h want %h", g, e); end end
         end
      end
      threshold_offset = 8'd0;
      m_offset = 0;
   endtask
`endif

   initial begin
      reset = 1; pixel = '0; pixel_valid = 0; local_average = '0; local_average_valid = 0;
`ifdef THRESHOLD_OFFSET_EN
      threshold_offset = 8'd0;
`endif
      m_offset = 0; exp_sync = 0; got_sync = 0;
      model_reset();
      test_reset();
      test_uniform();
      test_alternating();
      test_pre_sof();
      test_mid_line_sof();
      test_valid_mismatch();
      test_back_to_back();
`ifdef THRESHOLD_OFFSET_EN
      test_offset();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/local_threshold_packer.md
Name: local_threshold_packer

Overview:
- Consumes the SOF-tagged 9-bit pixel stream and the 8-bit local average produced by the local averaging stage.
- Compares each pixel against the average of the window centred on it, giving a 1-bit local-contrast map.
- Packs the bits into words for the block-matching memory writer, tracking frame and line position.

Parameters:
RADIUS, 8, half window width; the upstream window is 2*RADIUS samples and excludes the newest sample
IMG_WIDTH, 640, pixels per line; must be a multiple of PACK_WIDTH
PACK_WIDTH, 8, bits per output word

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
pixel  input  9  [8]=SOF, [7:0]=intensity; the delayed pixel from the averaging stage
pixel_valid  input  1  pixel qualifier
local_average  input  8  window average, same cycle as pixel
local_average_valid  input  1  average qualifier
out_word  output  PACK_WIDTH  packed threshold bits, column 0 of the word in bit 0
out_word_valid  output  1  one-cycle strobe per word
out_sof  output  1  high with the first word of each frame
sync_error  output  1  one-cycle pulse on a mid-line SOF or a valid mismatch

Behaviour:
- Reset values: all outputs 0, delay line 0, column counter 0, state IDLE.
- Reset applied mid-operation discards the partial word and the delay line.
- Accept: a sample is accepted only when pixel_valid && local_average_valid.
  - Exactly one of the two valids high: pulse sync_error next cycle, drop the sample, hold all state.
- Centring delay: shift register of RADIUS entries x 9 bits.
  - Advances only on accept.
  - The delayed pixel d is the sample accepted RADIUS accepts earlier, with its SOF bit.
  - Compare d[7:0] with the local_average of the current accept.
- Threshold bit: 1 if d[7:0] > local_average (unsigned, 9-bit compare), else 0.
  - Forced to 0 when the delayed column < RADIUS or > IMG_WIDTH-RADIUS. There the window crosses a line edge.
- States:
  - IDLE: discard accepts until a delayed sample with SOF=1 emerges, then go to RUN at column 0.
  - RUN: column counter increments per accept and wraps IMG_WIDTH-1 -> 0. The bit goes into the packing register at position column mod PACK_WIDTH.
- Word emission:
  - When column mod PACK_WIDTH == PACK_WIDTH-1, register the completed word.
  - out_word_valid rises the cycle after that accept (latency 1 from the completing accept).
  - out_sof is 1 if the word contains column 0 of the first line after a delayed SOF.
- Delayed SOF in RUN with column != 0:
  - Pulse sync_error.
  - Discard the partial word and restart at column 0.
  - The SOF sample itself becomes column 0 of a new frame.
- Delayed SOF at column 0 is normal frame start; no error.
- No internal flush: the last RADIUS pixels of a frame leave the delay line as the next frame's pixels arrive. Upstream streams frames back to back.
- Gaps in valid are allowed at any point; they do not change state.

Optional Feature:
- Macro THRESHOLD_OFFSET_EN.
- Defined:
  - Adds input port threshold_offset (8 bits, static per frame).
  - Bit = d[7:0] > local_average + threshold_offset, computed 9-bit so the sum does not wrap.
- Undefined: no port; offset is 0.

Decomposition:
- Shared package holds the state enum (IDLE, RUN) and the SOF bit index constant 8.
- Natural sub-module: pixel_delay_line (parameterised depth/width shift register with enable), reusable elsewhere in the gray path.

Test Plan:
1. Uniform frame, all pixels 100, SOF on the first one -> after fill, every word is 0x00; exactly IMG_WIDTH/8 words per line; out_sof on the first word only.
2. Line of alternating 0/200, average driven 100 -> interior words 0xAA or 0x55 by phase; columns 0-7 and 633-639 bits are 0.
3. Stream 16 pixels before SOF -> no out_word_valid until the SOF emerges from the delay line 8 accepts later.
4. SOF injected at delayed column 300 -> sync_error pulses once; the partial word is dropped; the next word has out_sof=1 and covers columns 0-7.
5. pixel_valid=1 with local_average_valid=0 for 1 cycle -> sync_error pulse; column count unchanged; output matches the gap-free run.
6. With THRESHOLD_OFFSET_EN, offset=20, d=115, average=100 -> bit 0; with d=121 -> bit 1; offset=200 with average=100 -> no wrap, bit 0 for d=255.
